mult_operand_dispatch_8: RTL and testbench
==========================================

MULT_OPERAND_DISPATCH_8 -- requirements
Module: mult_operand_dispatch_8

Interface
REQ-001 The block SHALL have one parameter: ZERO_IDLE, default 1; when 1, all mul_a_k/mul_b_k are 0 outside PH1/PH2; when 0, they hold their last value.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 The block SHALL have port sew, input, 2 bits: element width; 00 = 4x8-bit, 01 = 2x16-bit, 10 = 1x32-bit, 11 = reserved.
REQ-007 The block SHALL have ports operand_a and operand_b, input, 32 bits each: unsigned multiplicand and multiplier; bytes a0..a3 and b0..b3, with byte 0 in bits [7:0].
REQ-008 The block SHALL have ports mul_a_k and mul_b_k (k=1..8), output, 8 bits each: operand bytes for 8x8 multiplier k.
REQ-009 The block SHALL have port cs_start, output, 1 bit: one-cycle start pulse to the carry-save combiner.
REQ-010 The block SHALL have port cs_sew, output, 2 bits: the latched sew, driven to the combiner.
REQ-011 The block SHALL have port phase, output, 1 bit: 0 during PH1, 1 during PH2.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last operand phase.
REQ-013 The block SHALL have port sew_err, output, 1 bit: one-cycle pulse when sew=11 is accepted.

Function
REQ-014 The FSM SHALL have states IDLE, START, PH1, PH2, and every output SHALL be registered.
REQ-015 In_ready SHALL be 1 only in IDLE; an accept is in_valid && in_ready at a rising edge. At that edge, operand_a, operand_b and sew SHALL be latched.
REQ-016 On an accept with sew in {00,01,10}, the next state SHALL be START; in START, cs_start=1, cs_sew = latched sew, and the operand buses follow ZERO_IDLE.
REQ-017 START SHALL go to PH1. PH1 SHALL go to PH2 if sew=10, otherwise to IDLE. PH2 SHALL go to IDLE.
REQ-018 Done SHALL pulse in the first IDLE cycle after the last phase; an accept in that same cycle is legal, giving back-to-back throughput of 1 operand pair per 3 cycles (8/16-bit) or per 4 cycles (32-bit).
REQ-019 An accept with sew=11 SHALL leave the state in IDLE, pulse sew_err in the next cycle, and produce no cs_start and no done.
REQ-020 For sew=00 in PH1, pair k=1..4 SHALL be (a[k-1], b[k-1]), and pairs 5..8 SHALL be 0.
REQ-021 For sew=01 in PH1, the pairs SHALL be: 1=(a0,b0), 2=(a1,b0), 3=(a0,b1), 4=(a1,b1), 5=(a2,b2), 6=(a3,b2), 7=(a2,b3), 8=(a3,b3).
REQ-022 For sew=10 in PH1, the pairs SHALL be: 1=(a0,b0), 2=(a1,b0), 3=(a2,b0), 4=(a3,b0), 5=(a0,b1), 6=(a1,b1), 7=(a2,b1), 8=(a3,b1).
REQ-023 For sew=10 in PH2, the pairs SHALL be: 1=(a0,b2), 2=(a1,b2), 3=(a2,b2), 4=(a3,b2), 5=(a0,b3), 6=(a1,b3), 7=(a2,b3), 8=(a3,b3).
REQ-024 Across both phases, each of the 16 byte products (ai,bj), of weight 8*(i+j), SHALL be issued exactly once.
REQ-025 Changes on in_valid, operand_a, operand_b or sew outside IDLE SHALL have no effect.
REQ-026 Phase SHALL be 0 in all states except PH2.

Reset
REQ-027 Reset SHALL force state=IDLE, in_ready=1 (from the next evaluation), cs_start=0, cs_sew=00, phase=0, done=0, sew_err=0, all mul_a_k/mul_b_k=0 and the latched operands to 0.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first post-reset accept SHALL behave as from power-up.

Verification
REQ-029 Scenario 32-bit: sew=10, A=0x04030201, B=0x08070605 -> cs_start at cycle +1; PH1 at +2 drives pairs 1..8 = (01,05)(02,05)(03,05)(04,05)(01,06)(02,06)(03,06)(04,06); PH2 at +3 drives (01,07)(02,07)(03,07)(04,07)(01,08)(02,08)(03,08)(04,08); done at +4.
REQ-030 Scenario 16-bit: sew=01, A=0xDDCCBBAA, B=0x44332211 -> PH1 pairs (AA,11)(BB,11)(AA,22)(BB,22)(CC,33)(DD,33)(CC,44)(DD,44); no PH2; done at +3.
REQ-031 Scenario 8-bit: sew=00, A=0x04030201, B=0x08070605 -> pairs 1..4 = (01,05)(02,06)(03,07)(04,08), pairs 5..8 = 0, phase=0.
REQ-032 Scenario back-to-back: in_valid held high across two 8-bit ops -> second accept in the done cycle; cs_start pulses 3 cycles apart; operand changes outside IDLE are ignored.
REQ-033 Scenario reserved sew: sew=11 accepted -> sew_err pulses one cycle; no cs_start, no done; in_ready stays 1.
REQ-034 Scenario reset in PH1 of a 32-bit op -> all outputs go to reset values immediately; no PH2, no done; the next accept runs normally.

Source files
------------

// File: rtl/mult_operand_dispatch_8.sv
// Operand dispatcher for an 8x8-multiplier array: latches an operand pair and
// steers byte pairs to eight 8x8 multipliers over one or two phases by element width.
module mult_operand_dispatch_8 #(
    parameter bit ZERO_IDLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  sew,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [7:0]  mul_a_1,
    output logic [7:0]  mul_a_2,
    output logic [7:0]  mul_a_3,
    output logic [7:0]  mul_a_4,
    output logic [7:0]  mul_a_5,
    output logic [7:0]  mul_a_6,
    output logic [7:0]  mul_a_7,
    output logic [7:0]  mul_a_8,
    output logic [7:0]  mul_b_1,
    output logic [7:0]  mul_b_2,
    output logic [7:0]  mul_b_3,
    output logic [7:0]  mul_b_4,
    output logic [7:0]  mul_b_5,
    output logic [7:0]  mul_b_6,
    output logic [7:0]  mul_b_7,
    output logic [7:0]  mul_b_8,
    output logic        cs_start,
    output logic [1:0]  cs_sew,
    output logic        phase,
    output logic        done,
    output logic        sew_err
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned NUM_BYT = 4;
    localparam int unsigned NUM_MUL = 8;
    localparam int unsigned SEW_W   = 2;

    localparam logic [SEW_W-1:0] SEW_8   = 2'b00;
    localparam logic [SEW_W-1:0] SEW_16  = 2'b01;
    localparam logic [SEW_W-1:0] SEW_32  = 2'b10;
    localparam logic [SEW_W-1:0] SEW_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        PH1   = 2'd2,
        PH2   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [NUM_BYT-1:0][BYTE_W-1:0] op_a_q, op_a_d;
    logic [NUM_BYT-1:0][BYTE_W-1:0] op_b_q, op_b_d;
    logic [SEW_W-1:0]               sew_q, sew_d;

    logic [NUM_MUL-1:0][BYTE_W-1:0] mul_a_q, mul_a_d;
    logic [NUM_MUL-1:0][BYTE_W-1:0] mul_b_q, mul_b_d;

    logic in_ready_q, in_ready_d;
    logic cs_start_q, cs_start_d;
    logic phase_q, phase_d;
    logic done_q, done_d;
    logic sew_err_q, sew_err_d;

    logic [2:0] kk;
    logic [1:0] ai;
    logic [1:0] bj;

    // Next state, operand latch and next registered outputs.
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        sew_d      = sew_q;
        sew_err_d  = 1'b0;
        mul_a_d    = ZERO_IDLE ? '0 : mul_a_q;
        mul_b_d    = ZERO_IDLE ? '0 : mul_b_q;
        in_ready_d = 1'b0;
        cs_start_d = 1'b0;
        phase_d    = 1'b0;
        done_d     = 1'b0;
        kk         = '0;
        ai         = '0;
        bj         = '0;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_a_d = operand_a;
                    op_b_d = operand_b;
                    sew_d  = sew;
                    if (sew == SEW_RSV) begin
                        sew_err_d = 1'b1;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START:   state_d = PH1;
            PH1:     state_d = (sew_q == SEW_32) ? PH2 : IDLE;
            PH2:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        cs_start_d = (state_d == START);
        phase_d    = (state_d == PH2);
        done_d     = ((state_q == PH1) || (state_q == PH2)) && (state_d == IDLE);

        // Byte-pair steering: multiplier index k selects (a[ai], b[bj]).
        if ((state_d == PH1) || (state_d == PH2)) begin
            for (int k = 0; k < int'(NUM_MUL); k++) begin
                kk = 3'(k);
                unique case (sew_q)
                    SEW_8: begin
                        ai = kk[1:0];
                        bj = kk[1:0];
                        if (!kk[2]) begin
                            mul_a_d[k] = op_a_q[ai];
                            mul_b_d[k] = op_b_q[bj];
                        end else begin
                            mul_a_d[k] = '0;
                            mul_b_d[k] = '0;
                        end
                    end
                    SEW_16: begin
                        ai = {kk[2], kk[0]};
                        bj = {kk[2], kk[1]};
                        mul_a_d[k] = op_a_q[ai];
                        mul_b_d[k] = op_b_q[bj];
                    end
                    SEW_32: begin
                        ai = kk[1:0];
                        bj = {(state_d == PH2), kk[2]};
                        mul_a_d[k] = op_a_q[ai];
                        mul_b_d[k] = op_b_q[bj];
                    end
                    default: begin
                        mul_a_d[k] = '0;
                        mul_b_d[k] = '0;
                    end
                endcase
            end
        end
    end

    // State, latched operands and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            sew_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            in_ready_q <= 1'b1;
            cs_start_q <= 1'b0;
            phase_q    <= 1'b0;
            done_q     <= 1'b0;
            sew_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            sew_q      <= sew_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            in_ready_q <= in_ready_d;
            cs_start_q <= cs_start_d;
            phase_q    <= phase_d;
            done_q     <= done_d;
            sew_err_q  <= sew_err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign cs_start = cs_start_q;
    assign cs_sew   = sew_q;
    assign phase    = phase_q;
    assign done     = done_q;
    assign sew_err  = sew_err_q;

    assign mul_a_1 = mul_a_q[0];
    assign mul_a_2 = mul_a_q[1];
    assign mul_a_3 = mul_a_q[2];
    assign mul_a_4 = mul_a_q[3];
    assign mul_a_5 = mul_a_q[4];
    assign mul_a_6 = mul_a_q[5];
    assign mul_a_7 = mul_a_q[6];
    assign mul_a_8 = mul_a_q[7];
    assign mul_b_1 = mul_b_q[0];
    assign mul_b_2 = mul_b_q[1];
    assign mul_b_3 = mul_b_q[2];
    assign mul_b_4 = mul_b_q[3];
    assign mul_b_5 = mul_b_q[4];
    assign mul_b_6 = mul_b_q[5];
    assign mul_b_7 = mul_b_q[6];
    assign mul_b_8 = mul_b_q[7];

endmodule

// File: tb/tb_mult_operand_dispatch_8.sv
// Bench for mult_operand_dispatch_8: cycle schedule model plus directed literal checks.
module tb_mult_operand_dispatch_8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sew;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [7:0]  mul_a_1, mul_a_2, mul_a_3, mul_a_4, mul_a_5, mul_a_6, mul_a_7, mul_a_8;
    logic [7:0]  mul_b_1, mul_b_2, mul_b_3, mul_b_4, mul_b_5, mul_b_6, mul_b_7, mul_b_8;
    logic        cs_start;
    logic [1:0]  cs_sew;
    logic        phase;
    logic        done;
    logic        sew_err;

    always #5 clk = ~clk;

    mult_operand_dispatch_8 #(.ZERO_IDLE(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sew(sew), .operand_a(operand_a), .operand_b(operand_b),
        .mul_a_1(mul_a_1), .mul_a_2(mul_a_2), .mul_a_3(mul_a_3), .mul_a_4(mul_a_4),
        .mul_a_5(mul_a_5), .mul_a_6(mul_a_6), .mul_a_7(mul_a_7), .mul_a_8(mul_a_8),
        .mul_b_1(mul_b_1), .mul_b_2(mul_b_2), .mul_b_3(mul_b_3), .mul_b_4(mul_b_4),
        .mul_b_5(mul_b_5), .mul_b_6(mul_b_6), .mul_b_7(mul_b_7), .mul_b_8(mul_b_8),
        .cs_start(cs_start), .cs_sew(cs_sew), .phase(phase), .done(done), .sew_err(sew_err)
    );

    wire [63:0] a_bus = {mul_a_1, mul_a_2, mul_a_3, mul_a_4, mul_a_5, mul_a_6, mul_a_7, mul_a_8};
    wire [63:0] b_bus = {mul_b_1, mul_b_2, mul_b_3, mul_b_4, mul_b_5, mul_b_6, mul_b_7, mul_b_8};

    typedef struct packed {
        logic        in_ready;
        logic        cs_start;
        logic        phase;
        logic        done;
        logic        sew_err;
        logic [63:0] a;
        logic [63:0] b;
    } rec_t;

    int total = 0;
    int bad   = 0;

    rec_t        sched[$];
    rec_t        cur;
    logic [31:0] lat_a, lat_b;
    logic [1:0]  lat_sew;
    logic [134:0] got_v, want_v;

    function automatic rec_t mk(bit rdy, bit cs, bit dn, bit se);
        rec_t r;
        r = '0;
        r.in_ready = rdy;
        r.cs_start = cs;
        r.done     = dn;
        r.sew_err  = se;
        return r;
    endfunction

    // Pair tables written straight from the byte-pair lists; -1 means an unused multiplier.
    function automatic rec_t mk_phase(logic [1:0] s, bit p2, logic [31:0] a, logic [31:0] b);
        rec_t r;
        int ia[8];
        int ib[8];
        r = '0;
        r.phase = p2;
        case (s)
            2'b00: begin ia = '{0, 1, 2, 3, -1, -1, -1, -1}; ib = '{0, 1, 2, 3, -1, -1, -1, -1}; end
            2'b01: begin ia = '{0, 1, 0, 1, 2, 3, 2, 3};     ib = '{0, 0, 1, 1, 2, 2, 3, 3}; end
            default: begin
                ia = '{0, 1, 2, 3, 0, 1, 2, 3};
                if (p2) ib = '{2, 2, 2, 2, 3, 3, 3, 3};
                else    ib = '{0, 0, 0, 0, 1, 1, 1, 1};
            end
        endcase
        for (int k = 0; k < 8; k++) begin
            if (ia[k] >= 0) begin
                r.a[63-8*k -: 8] = a[8*ia[k] +: 8];
                r.b[63-8*k -: 8] = b[8*ib[k] +: 8];
            end
        end
        return r;
    endfunction

    task automatic chk(string nm, logic [127:0] got, logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
        end
    endtask

    // Model: every accept queues the exact sequence of output records that must follow.
    always @(posedge clk) begin
        if (reset) begin
            sched.delete();
            cur     = mk(1'b1, 1'b0, 1'b0, 1'b0);
            lat_a   = '0;
            lat_b   = '0;
            lat_sew = '0;
        end else begin
            if (in_valid && cur.in_ready) begin
                lat_a   = operand_a;
                lat_b   = operand_b;
                lat_sew = sew;
                if (sew == 2'b11) begin
                    sched.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1));
                end else begin
                    sched.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
                    sched.push_back(mk_phase(sew, 1'b0, operand_a, operand_b));
                    if (sew == 2'b10) sched.push_back(mk_phase(sew, 1'b1, operand_a, operand_b));
                    sched.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0));
                end
            end
            if (sched.size() > 0) cur = sched.pop_front();
            else                  cur = mk(1'b1, 1'b0, 1'b0, 1'b0);
        end
        #1;
        got_v  = {in_ready, cs_start, cs_sew, phase, done, sew_err, a_bus, b_bus};
        want_v = {cur.in_ready, cur.cs_start, lat_sew, cur.phase, cur.done, cur.sew_err, cur.a, cur.b};
        total++;
        if (got_v !== want_v) begin
            bad++;
            $display("FAIL cycle_model got=%h want=%h t=%0t", got_v, want_v, $time);
        end
    end

    task automatic offer(logic [1:0] s, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        in_valid  = 1'b1;
        sew       = s;
        operand_a = a;
        operand_b = b;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        sew       = 2'b00;
        operand_a = '0;
        operand_b = '0;
        #1;
        chk("reset_ctl", {in_ready, cs_start, cs_sew, phase, done, sew_err}, 7'b1000000);
        chk("reset_a", a_bus, 64'h0);
        chk("reset_b", b_bus, 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 32-bit operation: START, PH1, PH2, done.
        offer(2'b10, 32'h04030201, 32'h08070605);
        chk("s32_start", {cs_start, cs_sew, in_ready}, 4'b1100);
        @(negedge clk);
        chk("s32_ph1_a", a_bus, 64'h01020304_01020304);
        chk("s32_ph1_b", b_bus, 64'h05050505_06060606);
        chk("s32_ph1_phase", phase, 1'b0);
        @(negedge clk);
        chk("s32_ph2_a", a_bus, 64'h01020304_01020304);
        chk("s32_ph2_b", b_bus, 64'h07070707_08080808);
        chk("s32_ph2_phase", phase, 1'b1);
        @(negedge clk);
        chk("s32_done", {done, in_ready, phase}, 3'b110);
        @(negedge clk);

        // 16-bit operation: single phase.
        offer(2'b01, 32'hDDCCBBAA, 32'h44332211);
        @(negedge clk);
        chk("s16_ph1_a", a_bus, 64'hAABBAABB_CCDDCCDD);
        chk("s16_ph1_b", b_bus, 64'h11112222_33334444);
        @(negedge clk);
        chk("s16_done", {done, phase}, 2'b10);
        @(negedge clk);

        // 8-bit operation: upper four multipliers idle.
        offer(2'b00, 32'h04030201, 32'h08070605);
        @(negedge clk);
        chk("s8_ph1_a", a_bus, 64'h01020304_00000000);
        chk("s8_ph1_b", b_bus, 64'h05060708_00000000);
        chk("s8_phase", phase, 1'b0);
        @(negedge clk);
        chk("s8_done", done, 1'b1);
        @(negedge clk);

        // Back-to-back 8-bit with operand churn while busy.
        @(negedge clk);
        in_valid  = 1'b1;
        sew       = 2'b00;
        operand_a = 32'h44332211;
        operand_b = 32'h88776655;
        @(negedge clk);
        chk("b2b_start1", cs_start, 1'b1);
        operand_a = 32'hFFFFFFFF;
        operand_b = 32'hFFFFFFFF;
        sew       = 2'b10;
        @(negedge clk);
        chk("b2b_ph1_a", a_bus, 64'h11223344_00000000);
        chk("b2b_ph1_b", b_bus, 64'h55667788_00000000);
        operand_a = 32'h0D0C0B0A;
        operand_b = 32'h1D1C1B1A;
        sew       = 2'b00;
        @(negedge clk);
        chk("b2b_done1", {done, in_ready, cs_start}, 3'b110);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_start2", {cs_start, cs_sew}, 3'b100);
        @(negedge clk);
        chk("b2b_ph1_a2", a_bus, 64'h0A0B0C0D_00000000);
        chk("b2b_ph1_b2", b_bus, 64'h1A1B1C1D_00000000);
        @(negedge clk);
        chk("b2b_done2", done, 1'b1);
        @(negedge clk);

        // Reserved element width.
        offer(2'b11, 32'h12345678, 32'h9ABCDEF0);
        chk("rsv_err", {sew_err, cs_start, done, in_ready, cs_sew}, 6'b100111);
        @(negedge clk);
        chk("rsv_after", {sew_err, cs_start, done, in_ready}, 4'b0001);
        @(negedge clk);

        // Reset during PH1 of a 32-bit op, then a clean 16-bit op.
        offer(2'b10, 32'h04030201, 32'h08070605);
        @(negedge clk);
        chk("rst_pre_ph1_b", b_bus, 64'h05050505_06060606);
        reset = 1'b1;
        #1;
        chk("rst_mid_ctl", {in_ready, cs_start, cs_sew, phase, done, sew_err}, 7'b1000000);
        chk("rst_mid_a", a_bus, 64'h0);
        chk("rst_mid_b", b_bus, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_no_done", {done, phase}, 2'b00);
        offer(2'b01, 32'hDDCCBBAA, 32'h44332211);
        chk("rst_next_start", {cs_start, cs_sew}, 3'b101);
        @(negedge clk);
        chk("rst_next_a", a_bus, 64'hAABBAABB_CCDDCCDD);
        @(negedge clk);
        chk("rst_next_done", done, 1'b1);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
